ulpi_link_io: RTL and testbench
===============================

# ulpi_link_io

Parametrised, registered ULPI link-side I/O layer that replaces the pure pad-wrapper approach. It sits between the vendor pad buffers and the ULPI link controller. It registers all PHY inputs and outputs and generates the data-bus output enable with correct turnaround timing. It splits incoming bytes into RX data and RX CMD, tracks the last RX CMD (line state, RX event), and sequences PHY reset and startup before handing the bus to the link.

## Interface
Parameters:
- DATA_W, 8, ULPI data bus width; only 8 is supported, any other value is an elaboration error.
- RST_CYCLES, 64, clk cycles `phy_rst` is held high after reset (≥1).

Ports:
- clk  in  1  ULPI clock, already buffered; the only clock.
- rst  in  1  synchronous, active-high reset.
- phy_rst  out  1  PHY reset, active-high.
- phy_dir  in  1  PHY dir pad input.
- phy_nxt  in  1  PHY nxt pad input.
- phy_stp  out  1  stp to pad.
- phy_data_i  in  DATA_W  data pad input.
- phy_data_o  out  DATA_W  data to pad.
- phy_data_oe  out  1  data tristate enable; 1 = link drives.
- ready  out  1  startup complete; link may use the bus.
- tx_data  in  DATA_W  byte to drive next cycle.
- tx_stp  in  1  assert stp next cycle.
- dir  out  1  registered dir.
- nxt  out  1  registered nxt.
- turnaround  out  1  current cycle is a bus turnaround.
- rx_valid  out  1  rx_data holds a received data byte.
- rx_data  out  DATA_W  received data byte.
- rx_cmd_valid  out  1  rx_cmd updated this cycle.
- rx_cmd  out  DATA_W  last RX CMD, held.
- line_state  out  2  rx_cmd[1:0].
- rx_active  out  1  dir & (rx_cmd[5:4] ∈ {01,11}).

## Operation
- Input stage: `dir_r`, `nxt_r`, `data_r` capture the pads on every clk. `dir_rr` is `dir_r` delayed one cycle. `dir = dir_r` and `nxt = nxt_r`.
- `turnaround = dir_r ^ dir_rr`.
- RX classification applies only when `dir_r & dir_rr`:
  - `nxt_r = 1`: `rx_valid = 1`, `rx_data = data_r`.
  - `nxt_r = 0`: `rx_cmd_valid = 1`, `rx_cmd` register loads `data_r`.
- No RX output is asserted during turnaround or while `dir_r = 0`.
- Output stage:
  - `phy_data_o <= ready ? tx_data : 0`
  - `phy_stp <= ready & tx_stp`
- Output enable: `phy_data_oe = ready_r & ~phy_dir & ~dir_r`. It is combinational from the raw pad so the link releases the bus in the same cycle dir rises. It stays low for the turnaround cycle after dir falls.
- Startup FSM:
  - RESET: `phy_rst = 1`. The counter counts to RST_CYCLES-1, then the FSM moves to WAIT_DIR.
  - WAIT_DIR: `phy_rst = 0`. The FSM moves to READY when `dir_r = 0 & dir_rr = 0`. While the PHY holds dir high, the FSM waits indefinitely.
  - READY: `ready = 1`. The FSM stays here until rst.
- `rst` in any state forces RESET on the next edge. Counter and `rx_cmd` clear, and all outputs go to reset values.

## Timing
- Reset values:
  - `phy_rst = 1`
  - `phy_stp = 0`, `phy_data_o = 0`, `phy_data_oe = 0`
  - `ready = 0`, `dir = 0`, `nxt = 0`, `turnaround = 0`
  - `rx_valid = 0`, `rx_cmd_valid = 0`, `rx_data = 0`, `rx_cmd = 0`
- `phy_rst` is high for exactly RST_CYCLES cycles after rst deasserts.
- Pad to `dir`/`nxt`/`rx_*`: 1 cycle. `rx_cmd` updates on the edge after `rx_cmd_valid`.
- `tx_data`/`tx_stp` to pad: 1 cycle.
- `ready` asserts ≥2 cycles after leaving RESET, and 2 cycles after dir is last seen low.
- Dir rising while the link is transmitting: `phy_data_oe` drops the same cycle. The higher layer must discard its packet; this block does not retry.
- Counter width is `$clog2(RST_CYCLES+1)`. It saturates and never wraps.

## Structure
- Package `ulpi_pkg`:
  - RX CMD field constants: LINESTATE [1:0], VBUS [3:2], RXEVENT [5:4].
  - RXEVENT encodings: NONE 00, ACTIVE 01, HOSTDISC 10, ERROR 11.
  - Startup state enum {RESET, WAIT_DIR, READY}.
- Sub-module `ulpi_rst_seq` holds the startup FSM and counter.
- Pad primitives stay in the vendor wrapper, driven by `phy_data_o`/`phy_data_oe`.

## Test plan
- Reset release, RST_CYCLES=4, phy_dir=0 -> `phy_rst` high 4 cycles; `ready` rises on cycle 6 after rst falls.
- PHY holds dir=1 for 20 cycles after `phy_rst` falls -> `ready` stays 0 until 2 cycles after dir falls; `phy_data_oe` stays 0 throughout.
- Dir rises with data 0x4D, nxt=0, then 0xA5 with nxt=1 -> `turnaround` in cycle 1, `rx_cmd = 0x4D`, `line_state = 01`, `rx_active = 0`. Next, `rx_valid` with `rx_data = 0xA5`.
- RX CMD 0x11 while dir held -> `rx_active = 1`. Dir falls -> `rx_active = 0`, `turnaround = 1`, `phy_data_oe` low that cycle and high the next.
- `tx_data = 0x40`, `tx_stp` pulse when ready -> pad shows 0x40 / stp one cycle later. Dir rising mid-TX -> `phy_data_oe` low in the same cycle.
- rst asserted in READY during RX -> next cycle all outputs at reset values, `rx_cmd = 0`, `phy_rst = 1`.

Source files
------------

// File: rtl/ulpi_pkg.sv
// rtl/ulpi_pkg.sv - shared ULPI RX CMD field layout and startup state encoding
package ulpi_pkg;

   // RX CMD byte field positions
   localparam int RXCMD_LINESTATE_LO = 0;
   localparam int RXCMD_LINESTATE_HI = 1;
   localparam int RXCMD_VBUS_LO      = 2;
   localparam int RXCMD_VBUS_HI      = 3;
   localparam int RXCMD_RXEVENT_LO   = 4;
   localparam int RXCMD_RXEVENT_HI   = 5;

   typedef enum logic [1:0] {
      RXEVT_NONE     = 2'b00,
      RXEVT_ACTIVE   = 2'b01,
      RXEVT_HOSTDISC = 2'b10,
      RXEVT_ERROR    = 2'b11
   } rxevent_e;

   typedef enum logic [1:0] {
      RESET    = 2'b00,
      WAIT_DIR = 2'b01,
      READY    = 2'b10
   } startup_state_e;

   // A receive is in progress for both the ACTIVE and ERROR event codes.
   function automatic logic rxevent_is_active(input logic [1:0] evt);
      return (evt == RXEVT_ACTIVE) || (evt == RXEVT_ERROR);
   endfunction

endpackage

// File: rtl/ulpi_rst_seq.sv
// rtl/ulpi_rst_seq.sv - PHY reset pulse and startup handshake before the link owns the bus
module ulpi_rst_seq
   import ulpi_pkg::*;
#(
   parameter int RST_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic dir_r,
   input  logic dir_rr,
   output logic phy_rst,
   output logic ready
);

   localparam int              CNT_W    = $clog2(RST_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

   startup_state_e   state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RESET;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next state; the counter stops at its last value so it can never wrap
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      phy_rst  = 1'b0;
      ready    = 1'b0;
      case (state)
         RESET: begin
            phy_rst = 1'b1;
            if (cnt == CNT_LAST) state_nx = WAIT_DIR;
            else                 cnt_nx   = cnt + 1'b1;
         end
         WAIT_DIR: begin
            // PHY signals end of its own startup by releasing dir for two cycles
            if (!dir_r && !dir_rr) state_nx = READY;
         end
         READY: begin
            ready = 1'b1;
         end
         default: state_nx = RESET;
      endcase
   end

endmodule

// File: rtl/ulpi_link_io.sv
// rtl/ulpi_link_io.sv - registered ULPI link-side I/O layer with RX split and turnaround control
module ulpi_link_io
   import ulpi_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int RST_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   output logic              phy_rst,
   input  logic              phy_dir,
   input  logic              phy_nxt,
   output logic              phy_stp,
   input  logic [DATA_W-1:0] phy_data_i,
   output logic [DATA_W-1:0] phy_data_o,
   output logic              phy_data_oe,
   output logic              ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_stp,
   output logic              dir,
   output logic              nxt,
   output logic              turnaround,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_cmd_valid,
   output logic [DATA_W-1:0] rx_cmd,
   output logic [1:0]        line_state,
   output logic              rx_active
);

   if (DATA_W != 8) begin : g_bad_data_w
      $error("ulpi_link_io: DATA_W must be 8");
   end
   if (RST_CYCLES < 1) begin : g_bad_rst_cycles
      $error("ulpi_link_io: RST_CYCLES must be at least 1");
   end

   logic              dir_r, dir_rr, nxt_r;
   logic [DATA_W-1:0] data_r, rx_cmd_r;
   logic              rx_owned;

   // Pad capture; dir_rr keeps one cycle of dir history for turnaround detection
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_r  <= 1'b0;
         dir_rr <= 1'b0;
         nxt_r  <= 1'b0;
         data_r <= '0;
      end else begin
         dir_r  <= phy_dir;
         dir_rr <= dir_r;
         nxt_r  <= phy_nxt;
         data_r <= phy_data_i;
      end
   end

   assign dir        = dir_r;
   assign nxt        = nxt_r;
   assign turnaround = dir_r ^ dir_rr;

   // Bus belongs to the PHY and is past its turnaround cycle
   assign rx_owned     = dir_r & dir_rr;
   assign rx_valid     = rx_owned & nxt_r;
   assign rx_cmd_valid = rx_owned & ~nxt_r;
   assign rx_data      = data_r;

   // Hold the most recent RX CMD
   always_ff @(posedge clk) begin
      if (rst)               rx_cmd_r <= '0;
      else if (rx_cmd_valid) rx_cmd_r <= data_r;
   end

   assign rx_cmd     = rx_cmd_r;
   assign line_state = rx_cmd_r[RXCMD_LINESTATE_HI:RXCMD_LINESTATE_LO];
   assign rx_active  = dir_r & rxevent_is_active(rx_cmd_r[RXCMD_RXEVENT_HI:RXCMD_RXEVENT_LO]);

   // Transmit register; nothing reaches the pad until startup completes
   always_ff @(posedge clk) begin
      if (rst) begin
         phy_data_o <= '0;
         phy_stp    <= 1'b0;
      end else begin
         phy_data_o <= ready ? tx_data : '0;
         phy_stp    <= ready & tx_stp;
      end
   end

   // Raw pad dir releases the bus in the cycle dir rises; dir_r keeps it off for the turnaround after dir falls
   assign phy_data_oe = ready & ~phy_dir & ~dir_r;

   ulpi_rst_seq #(
      .RST_CYCLES (RST_CYCLES)
   ) u_rst_seq (
      .clk     (clk),
      .rst     (rst),
      .dir_r   (dir_r),
      .dir_rr  (dir_rr),
      .phy_rst (phy_rst),
      .ready   (ready)
   );

endmodule

// File: tb/tb_ulpi_link_io.sv
// tb/tb_ulpi_link_io.sv - self-checking bench for ulpi_link_io
module tb_ulpi_link_io;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       phy_rst;
   logic       phy_dir = 1'b0;
   logic       phy_nxt = 1'b0;
   logic       phy_stp;
   logic [7:0] phy_data_i = 8'h00;
   logic [7:0] phy_data_o;
   logic       phy_data_oe;
   logic       ready;
   logic [7:0] tx_data = 8'h00;
   logic       tx_stp = 1'b0;
   logic       dir, nxt, turnaround;
   logic       rx_valid, rx_cmd_valid, rx_active;
   logic [7:0] rx_data, rx_cmd;
   logic [1:0] line_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ulpi_link_io #(
      .DATA_W     (8),
      .RST_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .phy_rst      (phy_rst),
      .phy_dir      (phy_dir),
      .phy_nxt      (phy_nxt),
      .phy_stp      (phy_stp),
      .phy_data_i   (phy_data_i),
      .phy_data_o   (phy_data_o),
      .phy_data_oe  (phy_data_oe),
      .ready        (ready),
      .tx_data      (tx_data),
      .tx_stp       (tx_stp),
      .dir          (dir),
      .nxt          (nxt),
      .turnaround   (turnaround),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_cmd_valid (rx_cmd_valid),
      .rx_cmd       (rx_cmd),
      .line_state   (line_state),
      .rx_active    (rx_active)
   );

   typedef struct packed {
      logic       dir;
      logic       nxt;
      logic       ta;
      logic       rxv;
      logic [7:0] rxd;
      logic       rcv;
      logic [7:0] cmd;
      logic [1:0] ls;
      logic       act;
   } obs_t;

   typedef struct packed {
      logic       dir;
      logic       nxt;
      logic [7:0] data;
      obs_t       exp;
   } vec_t;

   vec_t       rx_tbl[13];
   obs_t       rx_q[$];
   logic [8:0] tx_tbl[4];
   logic [8:0] tx_q[$];
   int         rx_idx = 0;
   int         tx_idx = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string name);
      logic [35:0] a;
      a = {phy_rst, phy_stp, phy_data_o, phy_data_oe, ready, dir, nxt, turnaround,
           rx_valid, rx_cmd_valid, rx_data, rx_cmd, line_state, rx_active};
      check(name, 64'(a), 64'({1'b1, 35'd0}));
   endtask

   task automatic pop_rx();
      obs_t e, a;
      e = rx_q.pop_front();
      a = '{dir: dir, nxt: nxt, ta: turnaround, rxv: rx_valid, rxd: rx_data,
            rcv: rx_cmd_valid, cmd: rx_cmd, ls: line_state, act: rx_active};
      if (!e.rxv) a.rxd = e.rxd;
      check($sformatf("rx_vec%0d", rx_idx), 64'(a), 64'(e));
      rx_idx++;
   endtask

   task automatic pop_tx();
      logic [8:0] e;
      e = tx_q.pop_front();
      check($sformatf("tx_vec%0d", tx_idx), 64'({phy_stp, phy_data_o, phy_data_oe}), 64'({e, 1'b1}));
      tx_idx++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0] e3;

      // pad vector -> outputs seen the cycle after it is captured
      //                 dir   nxt   data    dir   nxt   ta    rxv   rxd    rcv   cmd    ls     act
      rx_tbl[0]  = '{1'b1, 1'b0, 8'h00, '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0}};
      rx_tbl[1]  = '{1'b1, 1'b0, 8'h4D, '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 2'b00, 1'b0}};
      rx_tbl[2]  = '{1'b1, 1'b1, 8'hA5, '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h4D, 2'b01, 1'b0}};
      rx_tbl[3]  = '{1'b1, 1'b0, 8'h11, '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h4D, 2'b01, 1'b0}};
      rx_tbl[4]  = '{1'b1, 1'b1, 8'h3C, '{1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h11, 2'b01, 1'b1}};
      rx_tbl[5]  = '{1'b1, 1'b0, 8'h2E, '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 2'b01, 1'b1}};
      rx_tbl[6]  = '{1'b1, 1'b0, 8'h33, '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h2E, 2'b10, 1'b0}};
      rx_tbl[7]  = '{1'b0, 1'b0, 8'h00, '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 2'b11, 1'b0}};
      rx_tbl[8]  = '{1'b0, 1'b0, 8'h00, '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h33, 2'b11, 1'b0}};
      rx_tbl[9]  = '{1'b1, 1'b1, 8'h77, '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 2'b11, 1'b1}};
      rx_tbl[10] = '{1'b1, 1'b0, 8'h30, '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 2'b11, 1'b1}};
      rx_tbl[11] = '{1'b0, 1'b0, 8'h00, '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h30, 2'b00, 1'b0}};
      rx_tbl[12] = '{1'b0, 1'b1, 8'h55, '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h30, 2'b00, 1'b0}};

      // {stp, data}
      tx_tbl[0] = 9'h140;
      tx_tbl[1] = 9'h012;
      tx_tbl[2] = 9'h1FF;
      tx_tbl[3] = 9'h000;

      // Reset values, then release with dir low: phy_rst for 4 cycles, ready in the 6th
      repeat (3) @(negedge clk);
      check_reset("reset_values");
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         e3 = {(k < 4), (k >= 5), 1'b0};
         check($sformatf("startup_c%0d", k), 64'({phy_rst, ready, 1'b0}), 64'(e3));
      end

      // PHY holds dir high through and well past its reset
      @(negedge clk);
      rst     = 1'b1;
      phy_dir = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge clk);
         e3 = {(k < 4), 2'b00};
         check($sformatf("dirhold_c%0d", k), 64'({phy_rst, ready, phy_data_oe}), 64'(e3));
      end
      @(negedge clk);
      phy_dir = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (j > 0) @(negedge clk);
         e3 = (j == 3) ? 3'b011 : 3'b000;
         check($sformatf("dirdrop_c%0d", j), 64'({phy_rst, ready, phy_data_oe}), 64'(e3));
      end

      // Transmit path, one cycle from tx inputs to pad
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (tx_q.size() > 0) pop_tx();
         tx_stp  = tx_tbl[i][8];
         tx_data = tx_tbl[i][7:0];
         tx_q.push_back(tx_tbl[i]);
      end
      @(negedge clk);
      pop_tx();

      // Receive classification
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         if (rx_q.size() > 0) pop_rx();
         phy_dir    = rx_tbl[i].dir;
         phy_nxt    = rx_tbl[i].nxt;
         phy_data_i = rx_tbl[i].data;
         rx_q.push_back(rx_tbl[i].exp);
      end
      @(negedge clk);
      pop_rx();

      // Dir rises while the link is driving
      phy_nxt    = 1'b0;
      phy_data_i = 8'h00;
      tx_data    = 8'h81;
      @(negedge clk);
      check("tx_before_dir", 64'({phy_data_o, phy_data_oe}), 64'({8'h81, 1'b1}));
      phy_dir = 1'b1;
      #1;
      check("oe_drop_same_cycle", 64'(phy_data_oe), 64'(1'b0));
      @(negedge clk);
      check("dir_rise_next", 64'({dir, turnaround, phy_data_oe}), 64'(3'b110));
      phy_nxt    = 1'b1;
      phy_data_i = 8'h99;
      @(negedge clk);
      check("rx_after_abort", 64'({rx_valid, rx_data}), 64'({1'b1, 8'h99}));

      // Reset in READY during a receive
      rst        = 1'b1;
      phy_data_i = 8'h9A;
      @(negedge clk);
      check_reset("rst_during_rx");

      rst = 1'b0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
